// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive path.
// CRC32 values follow the reflected IEEE 802.3 form.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected CRC32.
// Shared between the receive checker and the transmit path.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Bitwise LSB-first division, unrolled over the eight data bits
    always_comb begin
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY)
                                   : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/eth_rx_frame_checker.sv
// Ethernet receive front end: preamble/SFD hunt, FCS strip,
// CRC/length/address checks and saturating frame statistics.
module eth_rx_frame_checker
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
    parameter int          PRE_MIN      = 7,
    parameter int          MIN_LEN      = 64,
    parameter int          MAX_LEN      = 1518,
    parameter int          LEN_W        = 11,
    parameter int          CNT_W        = 16,
    parameter bit          PROMISC      = 1'b0,
    parameter bit          ACCEPT_MCAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic [2:0]       m_status,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [7:0]       pcnt;
    logic [31:0]      crc;
    logic [31:0]      crc_upd;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nxt;
    logic [31:0]      dly;
    logic [47:0]      mac_sr;
    logic             exact_ok;
    logic             bcast_ok;
    logic             mcast_ok;
    logic             exact_nxt;
    logic             bcast_nxt;
    logic             mcast_nxt;
    logic             addr_byte;
    logic             emit;
    logic [2:0]       status;

    eth_crc32_byte u_crc (
        .crc      (crc),
        .data     (in_data),
        .crc_next (crc_upd)
    );

    // Frame checks evaluated with the incoming byte included
    always_comb begin
        len_nxt   = (&len) ? len : len + 1'b1;
        addr_byte = len < LEN_W'(6);
        emit      = len >= LEN_W'(4);
        exact_nxt = exact_ok & (~addr_byte | (in_data == mac_sr[47:40]));
        bcast_nxt = bcast_ok & (~addr_byte | (in_data == ETH_BCAST[7:0]));
        mcast_nxt = (len == '0) ? in_data[0] : mcast_ok;
        status    = {PROMISC | exact_nxt | bcast_nxt
                     | (ACCEPT_MCAST & mcast_nxt),
                     ~(&len_nxt)
                     & (len_nxt >= LEN_W'(MIN_LEN))
                     & (len_nxt <= LEN_W'(MAX_LEN)),
                     crc_upd == CRC32_RESIDUE};
    end

    // Receive state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; idle cycles never move the machine
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            unique case (state)
                IDLE: if (!in_last && in_data == ETH_PREAMBLE) state_nxt = PRE;
                PRE: begin
                    if (in_last)
                        state_nxt = IDLE;
                    else if (in_data == ETH_SFD && pcnt >= 8'(PRE_MIN))
                        state_nxt = DATA;
                    else if (in_data != ETH_PREAMBLE)
                        state_nxt = DROP;
                end
                DATA:    if (in_last) state_nxt = IDLE;
                DROP:    if (in_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: preamble count, CRC, delay line, output and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            crc      <= CRC32_INIT;
            len      <= '0;
            dly      <= '0;
            mac_sr   <= '0;
            exact_ok <= 1'b0;
            bcast_ok <= 1'b0;
            mcast_ok <= 1'b0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_status <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_status <= '0;
            if (in_valid) begin
                unique case (state)
                    IDLE: pcnt <= 8'd1;
                    PRE: begin
                        if (in_data == ETH_PREAMBLE && pcnt != 8'hFF)
                            pcnt <= pcnt + 8'd1;
                        if (state_nxt == DATA) begin
                            crc      <= CRC32_INIT;
                            len      <= '0;
                            mac_sr   <= MAC_ADDR;
                            exact_ok <= 1'b1;
                            bcast_ok <= 1'b1;
                            mcast_ok <= 1'b0;
                        end
                    end
                    DATA: begin
                        crc      <= crc_upd;
                        len      <= len_nxt;
                        dly      <= {dly[23:0], in_data};
                        mac_sr   <= mac_sr << 8;
                        exact_ok <= exact_nxt;
                        bcast_ok <= bcast_nxt;
                        mcast_ok <= mcast_nxt;
                        if (emit) begin
                            m_valid <= 1'b1;
                            m_data  <= dly[31:24];
                            m_last  <= in_last;
                            if (in_last) m_status <= status;
                        end
                        if (in_last) begin
                            if (emit && status == 3'b111) begin
                                if (!(&good_cnt)) good_cnt <= good_cnt + 1'b1;
                            end else begin
                                if (!(&bad_cnt)) bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Directed and randomised frames against a frame-level reference model
// that derives output bytes, status and counters from whole frames.
module tb_eth_rx_frame_checker;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic [2:0]  m_status;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    int errors = 0;
    int checks = 0;
    int exp_good = 0;
    int exp_bad = 0;
    int last_hits = 0;
    int status_leak = 0;
    logic [2:0] got_status = '0;
    logic [2:0] exp_status = '0;

    byte unsigned got[$];
    byte unsigned exp_out[$];
    byte unsigned frame[$];
    byte unsigned saved[$];
    byte unsigned wire_q[$];

    always #5 clk = ~clk;

    eth_rx_frame_checker dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_status (m_status),
        .good_cnt (good_cnt),
        .bad_cnt  (bad_cnt)
    );

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            got.push_back(m_data);
            if (m_last) begin
                last_hits++;
                got_status = m_status;
            end
        end
        if (!m_last && m_status != 3'b000) status_leak++;
    end

    function automatic logic [31:0] crc32(input byte unsigned b[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame of n bytes (dest..FCS) with a correct FCS
    task automatic build(input logic [47:0] dest, input int n);
        logic [31:0] fcs;
        frame = {};
        for (int i = 0; i < 6; i++) frame.push_back(dest[47-8*i -: 8]);
        for (int i = 6; i < n - 4; i++) frame.push_back(8'($urandom));
        fcs = crc32(frame, n - 4);
        for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
    endtask

    // Reference model: what a received frame should produce
    task automatic model(input bit accepted);
        int n;
        logic [47:0] dest;
        logic a, l, f;
        n = frame.size();
        exp_out = {};
        exp_status = '0;
        got = {};
        last_hits = 0;
        if (!accepted) return;
        if (n <= 4) begin
            exp_bad++;
            return;
        end
        for (int i = 0; i < n - 4; i++) exp_out.push_back(frame[i]);
        dest = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        a = (dest == MAC) || (dest == 48'hFFFF_FFFF_FFFF) || dest[40];
        l = (n >= 64) && (n <= 1518);
        f = crc32(frame, n - 4)
            == {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
        exp_status = {a, l, f};
        if (exp_status == 3'b111) exp_good++;
        else exp_bad++;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles
    task automatic drive(input logic [7:0] d, input logic l, input int gap);
        int k;
        k = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic send_wire(input int gap, input int stop_at);
        for (int i = 0; i < wire_q.size(); i++) begin
            if (i == stop_at) return;
            drive(wire_q[i], i == wire_q.size() - 1, gap);
        end
    endtask

    task automatic make_wire(input int npre);
        wire_q = {};
        repeat (npre) wire_q.push_back(8'h55);
        wire_q.push_back(8'hD5);
        foreach (frame[i]) wire_q.push_back(frame[i]);
    endtask

    task automatic verify(input string tag);
        int mism;
        idle(4);
        mism = 0;
        check({tag, " count"}, got.size(), exp_out.size());
        for (int i = 0; i < got.size() && i < exp_out.size(); i++)
            if (got[i] != exp_out[i]) mism++;
        check({tag, " data"}, mism, 0);
        check({tag, " last"}, last_hits, (exp_out.size() > 0) ? 1 : 0);
        if (exp_out.size() > 0) check({tag, " status"}, got_status, exp_status);
        check({tag, " good_cnt"}, good_cnt, exp_good);
        check({tag, " bad_cnt"}, bad_cnt, exp_bad);
    endtask

    task automatic rx(input string tag, input int npre, input int gap);
        model(1'b1);
        make_wire(npre);
        send_wire(gap, -1);
        verify(tag);
    endtask

    initial begin
        logic [47:0] dests[4];
        dests[0] = MAC;
        dests[1] = 48'hFFFF_FFFF_FFFF;
        dests[2] = 48'h01_00_5E_00_00_01;
        dests[3] = 48'h02_00_00_00_00_02;

        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        check("reset m_valid", m_valid, 0);
        check("reset m_last", m_last, 0);
        check("reset m_status", m_status, 0);
        check("reset m_data", m_data, 0);
        check("reset good_cnt", good_cnt, 0);
        check("reset bad_cnt", bad_cnt, 0);
        rst = 1'b0;
        idle(2);

        build(MAC, 64);
        saved = frame;
        rx("good", 7, 0);

        frame = saved;
        frame[20] = frame[20] ^ 8'h08;
        rx("fcs_err", 7, 0);

        frame = {};
        repeat (3) frame.push_back(8'($urandom));
        rx("runt", 7, 1);

        frame = saved;
        rx("good_gaps", 7, 2);

        frame = {};
        repeat (12) frame.push_back(8'($urandom));
        model(1'b0);
        wire_q = {8'h55, 8'h55, 8'h55, 8'hD5};
        foreach (frame[i]) wire_q.push_back(frame[i]);
        send_wire(0, -1);
        verify("short_pre");

        model(1'b0);
        wire_q = {};
        repeat (7) wire_q.push_back(8'h55);
        wire_q.push_back(8'h12);
        foreach (frame[i]) wire_q.push_back(frame[i]);
        send_wire(2, -1);
        verify("bad_sfd");

        build(MAC, 64);
        rx("after_drop", 9, 0);

        build(48'hFFFF_FFFF_FFFF, 64);
        rx("bcast", 7, 2);

        build(48'h02_00_00_00_00_02, 64);
        rx("other_dest", 7, 0);

        build(MAC, 1519);
        rx("too_long", 7, 0);

        build(MAC, 1518);
        rx("max_len", 7, 0);

        build(MAC, 63);
        rx("min_minus1", 7, 0);

        for (int t = 0; t < 6; t++) begin
            build(dests[$urandom_range(0, 3)], int'($urandom_range(60, 90)));
            if ($urandom_range(0, 2) == 0)
                frame[$urandom_range(0, frame.size() - 1)] ^= 8'h01;
            rx("random", int'($urandom_range(7, 10)), 2);
        end

        build(MAC, 64);
        model(1'b1);
        make_wire(7);
        send_wire(0, 8 + 30);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst m_valid", m_valid, 0);
        check("rst good_cnt", good_cnt, 0);
        check("rst bad_cnt", bad_cnt, 0);
        exp_good = 0;
        exp_bad = 0;
        idle(2);

        frame = saved;
        rx("post_reset", 7, 0);

        check("status outside last", status_leak, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
